// File: rtl/pattern_buffer_loader.sv
// Serial load-port master for the pattern buffer bank: serialises one buffer image
// per frame MSB-first on sclk/sin/ssel and captures the sout return stream as words.
module pattern_buffer_loader #(
    parameter int BUFFER_SIZE  = 32,
    parameter int BUFFER_WIDTH = 6,
    parameter int CLK_DIV      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              buf_addr,
    input  logic [BUFFER_WIDTH-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [BUFFER_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    sin,
    output logic                    ssel,
    output logic [2:0]              saddr,
    input  logic                    sout
);

    localparam int WCW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int BCW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam int DCW = $clog2(CLK_DIV + 1);

    localparam logic [WCW-1:0] LAST_WORD = WCW'(BUFFER_SIZE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(BUFFER_WIDTH - 1);
    localparam logic [DCW-1:0] LAST_DIV  = DCW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, GAP} state_t;

    state_t                  state, state_n;
    logic [WCW-1:0]          word_cnt, word_cnt_n;
    logic [BCW-1:0]          bit_cnt, bit_cnt_n;
    logic [DCW-1:0]          div_cnt, div_cnt_n;
    logic [BUFFER_WIDTH-1:0] tx_sh, tx_sh_n;
    logic [BUFFER_WIDTH-1:0] rx_sh, rx_sh_n;
    logic [BUFFER_WIDTH-1:0] rx_next;
    logic [BUFFER_WIDTH-1:0] rd_data_n;
    logic                    wr_ready_n, rd_valid_n, busy_n, done_n;
    logic                    sclk_n, sin_n, ssel_n;
    logic [2:0]              saddr_n;

    assign rx_next = {rx_sh[BUFFER_WIDTH-2:0], sout};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rd_data  <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            sin      <= 1'b0;
            ssel     <= 1'b0;
            saddr    <= '0;
        end else begin
            state    <= state_n;
            word_cnt <= word_cnt_n;
            bit_cnt  <= bit_cnt_n;
            div_cnt  <= div_cnt_n;
            tx_sh    <= tx_sh_n;
            rx_sh    <= rx_sh_n;
            rd_data  <= rd_data_n;
            wr_ready <= wr_ready_n;
            rd_valid <= rd_valid_n;
            busy     <= busy_n;
            done     <= done_n;
            sclk     <= sclk_n;
            sin      <= sin_n;
            ssel     <= ssel_n;
            saddr    <= saddr_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_cnt_n = word_cnt;
        bit_cnt_n  = bit_cnt;
        div_cnt_n  = div_cnt;
        tx_sh_n    = tx_sh;
        rx_sh_n    = rx_sh;
        rd_data_n  = rd_data;
        wr_ready_n = wr_ready;
        rd_valid_n = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        sclk_n     = sclk;
        sin_n      = sin;
        ssel_n     = ssel;
        saddr_n    = saddr;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LOAD;
                    saddr_n    = buf_addr;
                    busy_n     = 1'b1;
                    word_cnt_n = '0;
                    wr_ready_n = 1'b1;
                end
            end
            LOAD: begin
                // stalls here with sclk low and ssel/sin untouched until a word arrives
                if (wr_valid && wr_ready) begin
                    tx_sh_n    = wr_data;
                    sin_n      = wr_data[BUFFER_WIDTH-1];
                    wr_ready_n = 1'b0;
                    ssel_n     = 1'b1;
                    sclk_n     = 1'b0;
                    bit_cnt_n  = '0;
                    div_cnt_n  = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == LAST_DIV) begin
                    div_cnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // end of high phase: capture sout, fall sclk and present the next bit together
                        sclk_n  = 1'b0;
                        rx_sh_n = rx_next;
                        tx_sh_n = tx_sh << 1;
                        sin_n   = tx_sh[BUFFER_WIDTH-2];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n  = '0;
                            rd_data_n  = rx_next;
                            rd_valid_n = 1'b1;
                            if (word_cnt == LAST_WORD) begin
                                state_n = HOLD;
                            end else begin
                                word_cnt_n = word_cnt + WCW'(1);
                                wr_ready_n = 1'b1;
                                state_n    = LOAD;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + BCW'(1);
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + DCW'(1);
                end
            end
            HOLD: begin
                if (div_cnt == LAST_DIV) begin
                    div_cnt_n = '0;
                    ssel_n    = 1'b0;
                    state_n   = GAP;
                end else begin
                    div_cnt_n = div_cnt + DCW'(1);
                end
            end
            GAP: begin
                if (div_cnt == LAST_DIV) begin
                    div_cnt_n = '0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end else begin
                    div_cnt_n = div_cnt + DCW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
